// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_pkg
// Brief    : Opcode constants, op-class bounds and FSM encoding for wb_stage.
// Revision : 1.0
// ============================================================================
package wb_stage_pkg;

    localparam logic [4:0] c_OP_ALU_MAX  = 5'b01110;
    localparam logic [4:0] c_OP_FLAG_MAX = 5'b01111;
    localparam logic [4:0] c_OP_CMP      = 5'b01111;
    localparam logic [4:0] c_OP_MOV      = 5'b10000;
    localparam logic [4:0] c_OP_LD       = 5'b10010;
    localparam logic [4:0] c_OP_STR      = 5'b10011;
    localparam logic [4:0] c_OP_MSR      = 5'b10100;
    localparam logic [4:0] c_OP_MRS      = 5'b10101;
    localparam logic [4:0] c_OP_PUSH     = 5'b10110;
    localparam logic [4:0] c_OP_POP      = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_STR  = 2'd1,
        ST_MEM_PUSH = 2'd2,
        ST_SP_WB    = 2'd3
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : wb_op_decode
// Brief    : Maps a core opcode onto the write-back effect classes.
// Revision : 1.0
// ============================================================================
module wb_op_decode
    import wb_stage_pkg::*;
(
    input  logic [4:0] op,
    output logic       is_reg,
    output logic       is_flag,
    output logic       is_str,
    output logic       is_push
);

    always_comb begin
        is_flag = (op <= c_OP_FLAG_MAX);
        is_str  = (op == c_OP_STR);
        is_push = (op == c_OP_PUSH);
        // CMP sits in the flag range but is excluded from the register range
        is_reg  = (op <= c_OP_ALU_MAX) ||
                  (op == c_OP_MOV) || (op == c_OP_LD)  ||
                  (op == c_OP_MSR) || (op == c_OP_MRS) ||
                  (op == c_OP_POP);
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Pipeline write-back stage with store back-pressure and PUSH SP update.
// Revision : 1.0
// ============================================================================
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DW     = 16,
    parameter int RIDX_W = 5,
    parameter int SP_IDX = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        ex_wb_op,
    input  logic [DW-1:0]     ex_wb_result,
    input  logic [DW-1:0]     ex_wb_operand_b,
    input  logic [3:0]        ex_wb_nzcv,
    input  logic [RIDX_W-1:0] ex_wb_reg_idx_dst,
    input  logic              ex_wb_has_writeback,
    input  logic [DW-1:0]     sp_value,
    output logic              reg_w_en,
    output logic [RIDX_W-1:0] reg_w_idx,
    output logic [DW-1:0]     reg_w_data,
    output logic              flags_w_en,
    output logic [3:0]        flags,
    output logic              mem_w_valid,
    output logic [DW-1:0]     mem_w_addr,
    output logic [DW-1:0]     mem_w_data,
    input  logic              mem_w_ready,
    output logic              wb_ex_has_bypass,
    output logic [RIDX_W-1:0] wb_ex_bypass_reg,
    output logic [DW-1:0]     wb_ex_bypass_value
);

    localparam logic [RIDX_W-1:0] c_SP_REG = RIDX_W'(SP_IDX);
    localparam logic [DW-1:0]     c_ONE    = DW'(1);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;
    logic              w_is_reg;
    logic              w_is_flag;
    logic              w_is_str;
    logic              w_is_push;
    logic              w_accept;
    logic              w_reg_w_en_nxt;
    logic [RIDX_W-1:0] w_reg_w_idx_nxt;
    logic [DW-1:0]     w_reg_w_data_nxt;
    logic              w_flags_w_en_nxt;
    logic [3:0]        w_flags_nxt;
    logic              w_mem_w_valid_nxt;
    logic [DW-1:0]     w_mem_w_addr_nxt;
    logic [DW-1:0]     w_mem_w_data_nxt;

    wb_op_decode u_decode (
        .op      (ex_wb_op),
        .is_reg  (w_is_reg),
        .is_flag (w_is_flag),
        .is_str  (w_is_str),
        .is_push (w_is_push)
    );

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid & in_ready;

    assign wb_ex_has_bypass   = reg_w_en;
    assign wb_ex_bypass_reg   = reg_w_idx;
    assign wb_ex_bypass_value = reg_w_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            reg_w_en    <= 1'b0;
            reg_w_idx   <= '0;
            reg_w_data  <= '0;
            flags_w_en  <= 1'b0;
            flags       <= '0;
            mem_w_valid <= 1'b0;
            mem_w_addr  <= '0;
            mem_w_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            reg_w_en    <= w_reg_w_en_nxt;
            reg_w_idx   <= w_reg_w_idx_nxt;
            reg_w_data  <= w_reg_w_data_nxt;
            flags_w_en  <= w_flags_w_en_nxt;
            flags       <= w_flags_nxt;
            mem_w_valid <= w_mem_w_valid_nxt;
            mem_w_addr  <= w_mem_w_addr_nxt;
            mem_w_data  <= w_mem_w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_reg_w_en_nxt    = 1'b0;
        w_reg_w_idx_nxt   = reg_w_idx;
        w_reg_w_data_nxt  = reg_w_data;
        w_flags_w_en_nxt  = 1'b0;
        w_flags_nxt       = flags;
        w_mem_w_valid_nxt = mem_w_valid;
        w_mem_w_addr_nxt  = mem_w_addr;
        w_mem_w_data_nxt  = mem_w_data;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_reg && ex_wb_has_writeback) begin
                        w_reg_w_en_nxt   = 1'b1;
                        w_reg_w_idx_nxt  = ex_wb_reg_idx_dst;
                        w_reg_w_data_nxt = ex_wb_result;
                    end
                    if (w_is_flag) begin
                        w_flags_w_en_nxt = 1'b1;
                        w_flags_nxt      = ex_wb_nzcv;
                    end
                    if (w_is_str) begin
                        w_mem_w_valid_nxt = 1'b1;
                        w_mem_w_addr_nxt  = ex_wb_result;
                        w_mem_w_data_nxt  = ex_wb_operand_b;
                        w_state_nxt       = ST_MEM_STR;
                    end
                    // The held store address doubles as the latched SP-1
                    if (w_is_push) begin
                        w_mem_w_valid_nxt = 1'b1;
                        w_mem_w_addr_nxt  = sp_value - c_ONE;
                        w_mem_w_data_nxt  = ex_wb_result;
                        w_state_nxt       = ST_MEM_PUSH;
                    end
                end
            end
            ST_MEM_STR: begin
                if (mem_w_ready) begin
                    w_mem_w_valid_nxt = 1'b0;
                    w_state_nxt       = ST_IDLE;
                end
            end
            ST_MEM_PUSH: begin
                if (mem_w_ready) begin
                    w_mem_w_valid_nxt = 1'b0;
                    w_reg_w_en_nxt    = 1'b1;
                    w_reg_w_idx_nxt   = c_SP_REG;
                    w_reg_w_data_nxt  = mem_w_addr;
                    w_state_nxt       = ST_SP_WB;
                end
            end
            ST_SP_WB: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Self-checking bench for wb_stage: directed cases plus random ops.
// Revision : 1.0
// ============================================================================
module tb_wb_stage;

    localparam int DW     = 16;
    localparam int RIDX_W = 5;
    localparam int SP_IDX = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        ex_wb_op;
    logic [DW-1:0]     ex_wb_result;
    logic [DW-1:0]     ex_wb_operand_b;
    logic [3:0]        ex_wb_nzcv;
    logic [RIDX_W-1:0] ex_wb_reg_idx_dst;
    logic              ex_wb_has_writeback;
    logic [DW-1:0]     sp_value;
    logic              reg_w_en;
    logic [RIDX_W-1:0] reg_w_idx;
    logic [DW-1:0]     reg_w_data;
    logic              flags_w_en;
    logic [3:0]        flags;
    logic              mem_w_valid;
    logic [DW-1:0]     mem_w_addr;
    logic [DW-1:0]     mem_w_data;
    logic              mem_w_ready;
    logic              wb_ex_has_bypass;
    logic [RIDX_W-1:0] wb_ex_bypass_reg;
    logic [DW-1:0]     wb_ex_bypass_value;

    int n_checks = 0;
    int n_errors = 0;

    wb_stage #(.DW(DW), .RIDX_W(RIDX_W), .SP_IDX(SP_IDX)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .ex_wb_op            (ex_wb_op),
        .ex_wb_result        (ex_wb_result),
        .ex_wb_operand_b     (ex_wb_operand_b),
        .ex_wb_nzcv          (ex_wb_nzcv),
        .ex_wb_reg_idx_dst   (ex_wb_reg_idx_dst),
        .ex_wb_has_writeback (ex_wb_has_writeback),
        .sp_value            (sp_value),
        .reg_w_en            (reg_w_en),
        .reg_w_idx           (reg_w_idx),
        .reg_w_data          (reg_w_data),
        .flags_w_en          (flags_w_en),
        .flags               (flags),
        .mem_w_valid         (mem_w_valid),
        .mem_w_addr          (mem_w_addr),
        .mem_w_data          (mem_w_data),
        .mem_w_ready         (mem_w_ready),
        .wb_ex_has_bypass    (wb_ex_has_bypass),
        .wb_ex_bypass_reg    (wb_ex_bypass_reg),
        .wb_ex_bypass_value  (wb_ex_bypass_value)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Op classes straight from the opcode table, as integer ranges/lists
    function automatic void classify(input logic [4:0] op,
                                     output bit r, output bit f, output bit s, output bit p);
        int v;
        v = int'(op);
        f = (v <= 15);
        r = (v <= 14) || (v == 16) || (v == 18) || (v == 20) || (v == 21) || (v == 23);
        s = (v == 19);
        p = (v == 22);
    endfunction

    task automatic scramble_inputs();
        ex_wb_op            = 5'($urandom);
        ex_wb_result        = 16'($urandom);
        ex_wb_operand_b     = 16'($urandom);
        ex_wb_nzcv          = 4'($urandom);
        ex_wb_reg_idx_dst   = 5'($urandom);
        ex_wb_has_writeback = 1'($urandom);
        sp_value            = 16'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_reg_en"},   32'(reg_w_en),         32'd0);
        check({tag, "_flag_en"},  32'(flags_w_en),       32'd0);
        check({tag, "_mem_vld"},  32'(mem_w_valid),      32'd0);
        check({tag, "_byp_en"},   32'(wb_ex_has_bypass), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready),         32'd1);
    endtask

    // Called at a negedge with the stage idle; returns at a negedge, idle again.
    task automatic idle_cycle();
        in_valid    = 1'b0;
        mem_w_ready = 1'($urandom);
        scramble_inputs();
        @(posedge clk);
        @(negedge clk);
        check_quiet("idle");
    endtask

    task automatic run_op(input logic [4:0] op, input logic [4:0] dst,
                          input logic [15:0] res, input logic [15:0] opb,
                          input logic [3:0] nzcv, input logic hwb,
                          input logic [15:0] sp, input int delay);
        bit r, f, s, p;
        logic        exp_reg;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        classify(op, r, f, s, p);
        exp_reg  = r && hwb;
        exp_addr = s ? res : 16'(sp - 16'd1);
        exp_data = s ? opb : res;

        check("accept_ready", 32'(in_ready), 32'd1);
        in_valid            = 1'b1;
        ex_wb_op            = op;
        ex_wb_reg_idx_dst   = dst;
        ex_wb_result        = res;
        ex_wb_operand_b     = opb;
        ex_wb_nzcv          = nzcv;
        ex_wb_has_writeback = hwb;
        sp_value            = sp;
        mem_w_ready         = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();

        check("reg_en",   32'(reg_w_en),         32'(exp_reg));
        check("byp_en",   32'(wb_ex_has_bypass), 32'(exp_reg));
        check("flag_en",  32'(flags_w_en),       32'(f));
        check("mem_vld",  32'(mem_w_valid),      32'(s || p));
        if (exp_reg) begin
            check("reg_idx",   32'(reg_w_idx),          32'(dst));
            check("reg_data",  32'(reg_w_data),         32'(res));
            check("byp_reg",   32'(wb_ex_bypass_reg),   32'(dst));
            check("byp_value", 32'(wb_ex_bypass_value), 32'(res));
        end
        if (f) check("flags", 32'(flags), 32'(nzcv));
        if (!(s || p)) begin
            check("ready_after_reg", 32'(in_ready), 32'd1);
            return;
        end

        for (int k = 0; k <= delay; k++) begin
            check("mem_hold_vld",  32'(mem_w_valid), 32'd1);
            check("mem_hold_addr", 32'(mem_w_addr),  32'(exp_addr));
            check("mem_hold_data", 32'(mem_w_data),  32'(exp_data));
            check("mem_busy",      32'(in_ready),    32'd0);
            check("mem_no_reg",    32'(reg_w_en),    32'd0);
            mem_w_ready = (k == delay);
            @(posedge clk);
            @(negedge clk);
        end
        mem_w_ready = 1'($urandom);
        check("mem_done_vld", 32'(mem_w_valid), 32'd0);
        if (s) begin
            check("str_ready", 32'(in_ready), 32'd1);
            check("str_no_reg", 32'(reg_w_en), 32'd0);
        end else begin
            check("sp_en",       32'(reg_w_en),           32'd1);
            check("sp_idx",      32'(reg_w_idx),          32'(SP_IDX));
            check("sp_data",     32'(reg_w_data),         32'(exp_addr));
            check("sp_byp_en",   32'(wb_ex_has_bypass),   32'd1);
            check("sp_byp_reg",  32'(wb_ex_bypass_reg),   32'(SP_IDX));
            check("sp_byp_val",  32'(wb_ex_bypass_value), 32'(exp_addr));
            check("sp_busy",     32'(in_ready),           32'd0);
            @(posedge clk);
            @(negedge clk);
            check("sp_en_clear", 32'(reg_w_en), 32'd0);
            check("push_ready",  32'(in_ready), 32'd1);
        end
    endtask

    // Abort a pending mem transaction with an asynchronous mid-cycle reset
    task automatic reset_during(input logic [4:0] op, input string tag);
        in_valid    = 1'b1;
        ex_wb_op    = op;
        ex_wb_result = 16'h0040;
        ex_wb_operand_b = 16'hBEEF;
        sp_value    = 16'h1000;
        mem_w_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_pending"}, 32'(mem_w_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check({tag, "_async_vld"},   32'(mem_w_valid), 32'd0);
        check({tag, "_async_ready"}, 32'(in_ready),    32'd1);
        mem_w_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        check_quiet({tag, "_post"});
        idle_cycle();
        idle_cycle();
    endtask

    initial begin
        int delay;
        logic [4:0] op;
        reset       = 1'b0;
        in_valid    = 1'b1;
        mem_w_ready = 1'b1;
        ex_wb_op            = 5'b00001;
        ex_wb_result        = 16'h1234;
        ex_wb_operand_b     = 16'h0;
        ex_wb_nzcv          = 4'b1000;
        ex_wb_reg_idx_dst   = 5'd3;
        ex_wb_has_writeback = 1'b1;
        sp_value            = 16'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_idx",  32'(reg_w_idx),  32'd0);
        check("reset_data", 32'(reg_w_data), 32'd0);
        check("reset_flags", 32'(flags),     32'd0);
        check("reset_addr", 32'(mem_w_addr), 32'd0);
        check("reset_mdata", 32'(mem_w_data), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        idle_cycle();

        // ADD, then enables must drop the following cycle
        run_op(5'b00001, 5'd3, 16'h1234, 16'h0000, 4'b1000, 1'b1, 16'h0000, 0);
        idle_cycle();
        // CMP: flags only
        run_op(5'b01111, 5'd7, 16'hAAAA, 16'h0000, 4'b0110, 1'b1, 16'h0000, 0);
        // MOV without writeback qualifier
        run_op(5'b10000, 5'd9, 16'h7777, 16'h0000, 4'b0000, 1'b0, 16'h0000, 0);
        idle_cycle();
        // STR with three cycles of back-pressure
        run_op(5'b10011, 5'd0, 16'h0040, 16'hBEEF, 4'b0000, 1'b1, 16'h0000, 3);
        // PUSH with SP wrap
        run_op(5'b10110, 5'd0, 16'h55AA, 16'h0000, 4'b0000, 1'b1, 16'h0000, 0);
        idle_cycle();

        reset_during(5'b10011, "rst_str");
        reset_during(5'b10110, "rst_push");

        for (int i = 0; i < 80; i++) begin
            op = 5'($urandom);
            if ($urandom_range(0, 3) == 0)
                op = ($urandom_range(0, 1) == 0) ? 5'b10011 : 5'b10110;
            delay = $urandom_range(0, 3);
            run_op(op, 5'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                   1'($urandom), ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
                   delay);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
